// File: rtl/ycr_wb_sram_resp_pkg.sv
// Shared widths and the FSM state type for the Wishbone SRAM burst responder.
//   YCR_WB_WIDTH    : Wishbone data/address width
//   YCR_WB_BL_DMEM  : burst-length field width (also width of the beat counters)
//   YCR_SRAM_AW     : SRAM word-address width
//   YCR_WB_SEL_W    : byte-enable width
package ycr_wb_sram_resp_pkg;

  localparam int unsigned YCR_WB_WIDTH   = 32;
  localparam int unsigned YCR_WB_BL_DMEM = 10;
  localparam int unsigned YCR_SRAM_AW    = 9;
  localparam int unsigned YCR_WB_SEL_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_ERR  = 2'd3
  } wb_resp_state_e;

  typedef logic [YCR_WB_BL_DMEM-1:0] wb_bl_cnt_t;

endpackage

// File: rtl/ycr_wb_rd_hold.sv
// Read-side datapath of the responder: issues SRAM reads, tracks the single
// in-flight read and holds the returned word until the master takes it.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : load the number of reads to issue (burst accepted)
//   i_bl_eff       : beats in the burst (already forced to >= 1)
//   i_active       : responder is in RD with stb&cyc high; low discards all state
//   i_bry          : master ready for the current beat
//   i_mem_dout     : SRAM read data, valid the cycle after a read issue
//   o_issue_c      : issue an SRAM read this cycle
//   o_ack_c        : beat delivered this cycle
//   o_rd_dat       : holding register (drives wbd_dat_o)
module ycr_wb_rd_hold
  import ycr_wb_sram_resp_pkg::*;
#(
  parameter int unsigned WB_WIDTH = YCR_WB_WIDTH,
  parameter int unsigned BL_W     = YCR_WB_BL_DMEM
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [BL_W-1:0]     i_bl_eff,
  input  logic                i_active,
  input  logic                i_bry,
  input  logic [WB_WIDTH-1:0] i_mem_dout,
  output logic                o_issue_c,
  output logic                o_ack_c,
  output logic [WB_WIDTH-1:0] o_rd_dat
);

  logic [BL_W-1:0]     r_issue_left;
  logic                r_inflight;
  logic                r_vld;
  logic [WB_WIDTH-1:0] r_rd_dat;

  logic w_ack;
  logic w_issue;

  // A new read may go out when the holding register is free or is being
  // emptied this cycle, and nothing is already in flight.
  assign w_ack     = i_active & r_vld & i_bry;
  assign w_issue   = i_active & (r_issue_left != '0) & ~r_inflight & (~r_vld | w_ack);
  assign o_ack_c   = w_ack;
  assign o_issue_c = w_issue;
  assign o_rd_dat  = r_rd_dat;

  // Issue counter, in-flight flag and holding register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_issue_left <= '0;
      r_inflight   <= 1'b0;
      r_vld        <= 1'b0;
      r_rd_dat     <= '0;
    end else begin
      if (i_start) begin
        r_issue_left <= i_bl_eff;
      end else if (w_issue) begin
        r_issue_left <= r_issue_left - BL_W'(1);
      end

      if (!i_active) begin
        // Abort or burst end: any landing read is dropped.
        r_inflight <= 1'b0;
        r_vld      <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (r_inflight) begin
          r_vld    <= 1'b1;
          r_rd_dat <= i_mem_dout;
        end else if (w_ack) begin
          r_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ycr_wb_sram_resp.sv
// Wishbone burst slave serving single/burst reads and writes from a
// single-port synchronous SRAM with one cycle of read latency.
//   wb_clk, wb_rst_n        : clock, async active-low reset
//   wbd_*_i                 : WB request (stb/cyc/adr/we/dat/sel/bl/bry)
//   wbd_dat_o/ack/lack/err  : WB response; ack/lack/err are combinational
//   mem_csb/web/addr/wmask/din, mem_dout : SRAM macro interface (active-low csb/web)
module ycr_wb_sram_resp
  import ycr_wb_sram_resp_pkg::*;
#(
  parameter int unsigned          WB_WIDTH  = YCR_WB_WIDTH,
  parameter int unsigned          BL_W      = YCR_WB_BL_DMEM,
  parameter int unsigned          AW        = YCR_SRAM_AW,
  parameter logic [WB_WIDTH-1:0]  BASE_ADDR = '0
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst_n,
  input  logic                    wbd_stb_i,
  input  logic                    wbd_cyc_i,
  input  logic [WB_WIDTH-1:0]     wbd_adr_i,
  input  logic                    wbd_we_i,
  input  logic [WB_WIDTH-1:0]     wbd_dat_i,
  input  logic [YCR_WB_SEL_W-1:0] wbd_sel_i,
  input  logic [BL_W-1:0]         wbd_bl_i,
  input  logic                    wbd_bry_i,
  output logic [WB_WIDTH-1:0]     wbd_dat_o,
  output logic                    wbd_ack_o,
  output logic                    wbd_lack_o,
  output logic                    wbd_err_o,
  output logic                    mem_csb,
  output logic                    mem_web,
  output logic [AW-1:0]           mem_addr,
  output logic [YCR_WB_SEL_W-1:0] mem_wmask,
  output logic [WB_WIDTH-1:0]     mem_din,
  input  logic [WB_WIDTH-1:0]     mem_dout
);

  wb_resp_state_e  r_state, w_state_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [BL_W-1:0] r_rem, w_rem_nxt;

  logic            w_req;
  logic            w_hit;
  logic [BL_W-1:0] w_bl_eff;
  logic            w_last;
  logic            w_wr_ack;
  logic            w_rd_ack;
  logic            w_rd_issue;
  logic            w_rd_active;
  logic            w_rd_start;
  logic [1:0]      w_unused_adr;

  assign w_req        = wbd_stb_i & wbd_cyc_i;
  assign w_hit        = (wbd_adr_i[WB_WIDTH-1:AW+2] == BASE_ADDR[WB_WIDTH-1:AW+2]);
  assign w_bl_eff     = (wbd_bl_i == '0) ? BL_W'(1) : wbd_bl_i;
  assign w_last       = (r_rem == BL_W'(1));
  assign w_wr_ack     = (r_state == ST_WR) & w_req & wbd_bry_i;
  assign w_rd_active  = (r_state == ST_RD) & w_req;
  assign w_unused_adr = wbd_adr_i[1:0];

  ycr_wb_rd_hold #(
    .WB_WIDTH (WB_WIDTH),
    .BL_W     (BL_W)
  ) u_rd_hold (
    .i_clk      (wb_clk),
    .i_rst_n    (wb_rst_n),
    .i_start    (w_rd_start),
    .i_bl_eff   (w_bl_eff),
    .i_active   (w_rd_active),
    .i_bry      (wbd_bry_i),
    .i_mem_dout (mem_dout),
    .o_issue_c  (w_rd_issue),
    .o_ack_c    (w_rd_ack),
    .o_rd_dat   (wbd_dat_o)
  );

  // State, beat address and remaining-beat counter.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Next state. r_addr tracks the next SRAM word to touch: advanced on each
  // write ack, and on each read issue (reads run ahead of acks).
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_rd_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_addr_nxt = wbd_adr_i[AW+1:2];
          w_rem_nxt  = w_bl_eff;
          if (!w_hit) begin
            w_state_nxt = ST_ERR;
          end else if (wbd_we_i) begin
            w_state_nxt = ST_WR;
          end else begin
            w_state_nxt = ST_RD;
            w_rd_start  = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wr_ack) begin
          w_addr_nxt = r_addr + AW'(1);
          w_rem_nxt  = r_rem - BL_W'(1);
          if (w_last) w_state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else begin
          if (w_rd_issue) w_addr_nxt = r_addr + AW'(1);
          if (w_rd_ack) begin
            w_rem_nxt = r_rem - BL_W'(1);
            if (w_last) w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Response and SRAM strobes.
  assign wbd_ack_o  = w_wr_ack | w_rd_ack;
  assign wbd_lack_o = (wbd_ack_o & w_last) | (r_state == ST_ERR);
  assign wbd_err_o  = (r_state == ST_ERR);
  assign mem_csb    = ~(w_wr_ack | w_rd_issue);
  assign mem_web    = ~w_wr_ack;
  assign mem_addr   = r_addr;
  assign mem_wmask  = w_wr_ack ? wbd_sel_i : '0;
  assign mem_din    = wbd_dat_i;

endmodule

// File: tb/tb_ycr_wb_sram_resp.sv
// Self-checking bench for ycr_wb_sram_resp: SRAM macro model, per-cycle
// monitor against a word-array memory model, and directed bursts.
module tb_ycr_wb_sram_resp;

  localparam int unsigned DEPTH = 512;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        stb, cyc, we, bry;
  logic [31:0] adr, dat_i;
  logic [3:0]  sel;
  logic [9:0]  bl;
  logic [31:0] dat_o;
  logic        ack, lack, err;
  logic        mem_csb, mem_web;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_din, mem_dout;

  always #5 wb_clk = ~wb_clk;

  ycr_wb_sram_resp dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .wbd_stb_i  (stb),
    .wbd_cyc_i  (cyc),
    .wbd_adr_i  (adr),
    .wbd_we_i   (we),
    .wbd_dat_i  (dat_i),
    .wbd_sel_i  (sel),
    .wbd_bl_i   (bl),
    .wbd_bry_i  (bry),
    .wbd_dat_o  (dat_o),
    .wbd_ack_o  (ack),
    .wbd_lack_o (lack),
    .wbd_err_o  (err),
    .mem_csb    (mem_csb),
    .mem_web    (mem_web),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // SRAM macro: synchronous, one cycle read latency, byte-masked writes.
  logic [31:0] sram [DEPTH];
  always @(posedge wb_clk) begin
    if (!mem_csb) begin
      if (!mem_web) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) sram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      end else begin
        mem_dout <= sram[mem_addr];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the current burst, set by the driver before stb rises.
  logic [31:0] model [DEPTH];
  logic [8:0]  m_start;
  int          m_n;
  bit          m_we;
  logic [3:0]  m_sel;
  bit          m_exp_err;
  int          m_acked = 0;

  // Per-cycle monitor: every ack must be qualified, carry the right word and
  // beat address, and lack must coincide with the final expected beat.
  always @(negedge wb_clk) begin : mon
    logic [8:0]  idx;
    logic [31:0] w;
    idx = m_start + 9'(m_acked);
    if (!wb_rst_n) begin
      check("rst_quiet", {31'd0, ack | lack | err | ~mem_csb}, 32'd0);
      m_acked <= 0;
    end else if (!stb) begin
      check("idle_quiet", {30'd0, ack, mem_csb}, 32'd1);
      m_acked <= 0;
    end else if (m_exp_err) begin
      check("err_noacc", {30'd0, ack, mem_csb}, 32'd1);
      check("err_lack", {31'd0, lack}, {31'd0, err});
    end else begin
      check("lack", {31'd0, lack}, {31'd0, ack && (m_acked + 1 == m_n)});
      check("no_err", {31'd0, err}, 32'd0);
      if (ack) check("ack_bry", {31'd0, bry}, 32'd1);
      if (m_we) begin
        check("wr_strobe", {30'd0, mem_csb, mem_web}, {30'd0, ~ack, ~ack});
        if (ack) begin
          check("wr_addr", {23'd0, mem_addr}, {23'd0, idx});
          check("wr_din", mem_din, dat_i);
          check("wr_mask", {28'd0, mem_wmask}, {28'd0, m_sel});
          w = model[idx];
          for (int b = 0; b < 4; b++)
            if (m_sel[b]) w[b*8 +: 8] = dat_i[b*8 +: 8];
          model[idx] <= w;
          m_acked <= m_acked + 1;
        end
      end else begin
        check("rd_web", {31'd0, mem_web}, 32'd1);
        if (ack) begin
          check("rd_data", dat_o, model[idx]);
          m_acked <= m_acked + 1;
        end
      end
    end
  end

  // Drive one burst; returns observed ack/err counts, ack cycle indices and
  // the data on the last read ack. Optional early abort or mid-burst reset.
  task automatic do_burst(input bit we_i, input logic [31:0] a, input int unsigned bl_i,
                          input logic [31:0] d0, input logic [31:0] dstep, input logic [3:0] s,
                          input bit toggle, input int abort_after, input int reset_at,
                          output int n_ack, output int n_err, output int first_ack,
                          output int last_ack, output logic [31:0] last_rd);
    int k;
    bit done;
    n_ack = 0; n_err = 0; first_ack = -1; last_ack = -1; last_rd = '0;
    done = 1'b0;
    m_we = we_i; m_start = a[10:2]; m_sel = s;
    m_n = (bl_i == 0) ? 1 : int'(bl_i);
    m_exp_err = (a[31:11] != '0);
    @(posedge wb_clk); #1;
    stb = 1; cyc = 1; we = we_i; adr = a; bl = 10'(bl_i); sel = s; dat_i = d0; bry = 1;
    k = 0;
    while (!done) begin
      @(negedge wb_clk);
      if (ack) begin
        if (n_ack == 0) first_ack = k;
        last_ack = k;
        last_rd = dat_o;
        n_ack++;
      end
      if (err) n_err++;
      if (lack) done = 1'b1;
      else if (abort_after > 0 && n_ack >= abort_after) done = 1'b1;
      else if (k >= 200) begin
        check("timeout", 32'd1, 32'd0);
        done = 1'b1;
      end
      @(posedge wb_clk); #1;
      k++;
      if (!done && reset_at > 0 && k == reset_at) begin
        wb_rst_n = 1'b0;
        done = 1'b1;
      end else if (!done) begin
        dat_i = d0 + dstep * 32'(n_ack);
        bry = toggle ? ~k[0] : 1'b1;
      end
    end
    stb = 0; cyc = 0; bry = 0;
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {28'd0, ack, lack, err, mem_csb & mem_web}, 32'd1);
    check({name, "_dat"}, dat_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int na, ne, fa, la;
    logic [31:0] rd;
    stb = 0; cyc = 0; we = 0; adr = 0; dat_i = 0; sel = 0; bl = 0; bry = 0;
    wb_rst_n = 0;
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    check_idle_outputs("reset_state");
    @(posedge wb_clk); #1 wb_rst_n = 1;
    @(negedge wb_clk);
    check_idle_outputs("post_reset");

    // Single write then read back.
    do_burst(1, 32'h10, 1, 32'hDEADBEEF, 0, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    check("single_wr_acks", 32'(na), 32'd1);
    do_burst(0, 32'h10, 1, 0, 0, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    check("single_rd_acks", 32'(na), 32'd1);
    check("single_rd_data", rd, 32'hDEADBEEF);

    // 8-beat write, bry held: acks back to back.
    do_burst(1, 32'h40, 8, 32'h1000_0000, 32'h0101, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    check("bw_acks", 32'(na), 32'd8);
    check("bw_consecutive", 32'(la - fa), 32'd7);

    // 4-beat read with bry toggling.
    do_burst(0, 32'h40, 4, 0, 0, 4'hF, 1, 0, 0, na, ne, fa, la, rd);
    check("br_toggle_acks", 32'(na), 32'd4);
    check("br_toggle_last", rd, 32'h1000_0303);

    // Full 8-beat read with bry held.
    do_burst(0, 32'h40, 8, 0, 0, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    check("br8_acks", 32'(na), 32'd8);
    check("br8_last", rd, 32'h1000_0707);

    // Partial byte write.
    do_burst(1, 32'h80, 1, 32'hFFFF_FFFF, 0, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    do_burst(1, 32'h80, 1, 32'h1234_5678, 0, 4'b0011, 0, 0, 0, na, ne, fa, la, rd);
    do_burst(0, 32'h80, 1, 0, 0, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    check("sel_merge", rd, 32'hFFFF_5678);

    // Out-of-window access.
    do_burst(0, 32'h0000_1000, 4, 0, 0, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    check("oow_acks", 32'(na), 32'd0);
    check("oow_errs", 32'(ne), 32'd1);

    // Address wrap at the top of the SRAM.
    do_burst(1, 32'h7FC, 2, 32'hA5A5_0001, 1, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    do_burst(0, 32'h000, 1, 0, 0, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    check("wrap_word0", rd, 32'hA5A5_0002);

    // Abort after 2 of 8 read beats.
    do_burst(0, 32'h40, 8, 0, 0, 4'hF, 0, 2, 0, na, ne, fa, la, rd);
    check("abort_acks", 32'(na), 32'd2);
    check("abort_last", rd, 32'h1000_0101);

    // Reset in the middle of a read burst, before its first ack.
    do_burst(0, 32'h50, 8, 0, 0, 4'hF, 0, 0, 3, na, ne, fa, la, rd);
    check("rst_burst_acks", 32'(na), 32'd0);
    @(negedge wb_clk);
    check_idle_outputs("mid_reset");
    @(posedge wb_clk);
    @(posedge wb_clk); #1 wb_rst_n = 1;
    @(negedge wb_clk);
    check_idle_outputs("after_mid_reset");

    // Accesses after reset, including bl=0 treated as one beat.
    do_burst(0, 32'h10, 1, 0, 0, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    check("post_rst_rd", rd, 32'hDEADBEEF);
    do_burst(0, 32'h5C, 0, 0, 0, 4'hF, 0, 0, 0, na, ne, fa, la, rd);
    check("bl0_acks", 32'(na), 32'd1);
    check("bl0_data", rd, 32'h1000_0707);

    repeat (3) @(posedge wb_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
